// File: rtl/ahb2apb_pkg.sv
// Shared encodings for the AHB-Lite to APB4 bridge: FSM states and AHB field constants.
package ahb2apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Slave index width, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // NONSEQ/SEQ carry a real transfer; IDLE/BUSY are ignored.
    function automatic logic htrans_active(input logic [1:0] t);
        return !((t == HTRANS_IDLE) || (t == HTRANS_BUSY));
    endfunction

endpackage

// File: rtl/ahb2apb_decoder.sv
// Combinational address/size decode: slave index, decode error and APB byte strobes.
module ahb2apb_decoder
    import ahb2apb_pkg::*;
#(
    parameter int unsigned  ADDR_WIDTH = 16,
    parameter int unsigned  NUM_SLV    = 4,
    parameter int unsigned  SLV_ADDR_W = 12,
    localparam int unsigned IDX_W      = idx_width(NUM_SLV)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    output logic [IDX_W-1:0]      idx,
    output logic                  err,
    output logic [3:0]            strb
);

    logic [ADDR_WIDTH-1:0] win;
    logic                  misalign;
    logic                  bad_size;

    // The whole window number is range-checked so addresses past the last slave fault.
    always_comb begin
        win      = addr >> SLV_ADDR_W;
        idx      = win[IDX_W-1:0];
        misalign = 1'b0;
        bad_size = 1'b0;
        strb     = 4'h0;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << addr[1:0];
            HSIZE_HALF: begin
                strb     = 4'b0011 << addr[1:0];
                misalign = addr[0];
            end
            HSIZE_WORD: begin
                strb     = 4'hF;
                misalign = |addr[1:0];
            end
            default:    bad_size = 1'b1;
        endcase
        err = (win >= ADDR_WIDTH'(NUM_SLV)) | misalign | bad_size;
    end

endmodule

// File: rtl/ahb2apb_bridge_mslv.sv
// AHB-Lite slave to multi-slave APB4 bridge with two-cycle ERROR response.
// Optional APB access timeout enabled by defining AHB2APB_TIMEOUT_EN.
module ahb2apb_bridge_mslv
    import ahb2apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned NUM_SLV    = 4,
    parameter int unsigned SLV_ADDR_W = 12,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   haddr_i,
    input  logic [1:0]              htrans_i,
    input  logic                    hwrite_i,
    input  logic [2:0]              hsize_i,
    input  logic [31:0]             hwdata_i,
    input  logic                    hsel_i,
    input  logic                    hready_i,
    output logic                    hready_o,
    output logic                    hresp_o,
    output logic [31:0]             hrdata_o,
    output logic [NUM_SLV-1:0]      psel_o,
    output logic                    penable_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic                    pwrite_o,
    output logic [31:0]             pwdata_o,
    output logic [3:0]              pstrb_o,
    input  logic [32*NUM_SLV-1:0]   prdata_i,
    input  logic [NUM_SLV-1:0]      pready_i,
    input  logic [NUM_SLV-1:0]      pslverr_i
);

    localparam int unsigned IDX_W = idx_width(NUM_SLV);

    state_t           state;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] dec_idx;
    logic             dec_err;
    logic [3:0]       dec_strb;
    logic             accept;
    logic             sel_ready;
    logic             sel_err;
    logic [31:0]      sel_rdata;
    logic             timeout;

    ahb2apb_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLV    (NUM_SLV),
        .SLV_ADDR_W (SLV_ADDR_W)
    ) u_decoder (
        .addr (haddr_i),
        .size (hsize_i),
        .idx  (dec_idx),
        .err  (dec_err),
        .strb (dec_strb)
    );

    assign accept    = hsel_i & hready_i & htrans_active(htrans_i);
    assign sel_ready = pready_i[idx_q];
    assign sel_err   = pslverr_i[idx_q];
    assign sel_rdata = prdata_i[{idx_q, 5'b0} +: 32];

`ifdef AHB2APB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt;

    // Counts ACCESS cycles; held at zero elsewhere so every ACCESS starts fresh.
    always_ff @(posedge clk_i) begin
        if (rst_i || (state != ST_ACCESS)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Fires in the TIMEOUT-th ACCESS cycle.
    assign timeout = (cnt == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            idx_q     <= '0;
            psel_o    <= '0;
            penable_o <= 1'b0;
            paddr_o   <= '0;
            pwrite_o  <= 1'b0;
            pwdata_o  <= '0;
            pstrb_o   <= 4'h0;
            hrdata_o  <= '0;
        end else begin
            case (state)
                // IDLE doubles as the completion cycle, so accepts here chain back-to-back.
                ST_IDLE, ST_ERR2: begin
                    state <= ST_IDLE;
                    if (accept) begin
                        if (dec_err) begin
                            state <= ST_ERR1;
                        end else begin
                            state    <= ST_SETUP;
                            idx_q    <= dec_idx;
                            psel_o   <= NUM_SLV'(1) << dec_idx;
                            paddr_o  <= haddr_i;
                            pwrite_o <= hwrite_i;
                            pstrb_o  <= hwrite_i ? dec_strb : 4'h0;
                        end
                    end
                end
                ST_SETUP: begin
                    state     <= ST_ACCESS;
                    penable_o <= 1'b1;
                    pwdata_o  <= hwdata_i;
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        psel_o    <= '0;
                        penable_o <= 1'b0;
                        if (sel_err) begin
                            state <= ST_ERR1;
                        end else begin
                            state <= ST_IDLE;
                            if (!pwrite_o) begin
                                hrdata_o <= sel_rdata;
                            end
                        end
                    end else if (timeout) begin
                        psel_o    <= '0;
                        penable_o <= 1'b0;
                        state     <= ST_ERR1;
                    end
                end
                ST_ERR1: state <= ST_ERR2;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign hready_o = (state == ST_IDLE) || (state == ST_ERR2);
    assign hresp_o  = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb2apb_bridge_mslv.sv
// Directed bench for ahb2apb_bridge_mslv; timeout case runs when AHB2APB_TIMEOUT_EN is defined.
module tb_ahb2apb_bridge_mslv;

    localparam int unsigned AW = 16;
    localparam int unsigned NS = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   haddr;
    logic [1:0]      htrans;
    logic            hwrite;
    logic [2:0]      hsize;
    logic [31:0]     hwdata;
    logic            hsel;
    logic            hready_bus;
    logic            hready_o;
    logic            hresp_o;
    logic [31:0]     hrdata_o;
    logic [NS-1:0]   psel_o;
    logic            penable_o;
    logic [AW-1:0]   paddr_o;
    logic            pwrite_o;
    logic [31:0]     pwdata_o;
    logic [3:0]      pstrb_o;
    logic [32*NS-1:0] prdata;
    logic [NS-1:0]   pready;
    logic [NS-1:0]   pslverr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Single-slave bus: the bus-wide ready is the bridge's own ready.
    assign hready_bus = hready_o;

    ahb2apb_bridge_mslv #(
        .ADDR_WIDTH (AW),
        .NUM_SLV    (NS),
        .SLV_ADDR_W (12),
        .TIMEOUT    (4)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .haddr_i   (haddr),
        .htrans_i  (htrans),
        .hwrite_i  (hwrite),
        .hsize_i   (hsize),
        .hwdata_i  (hwdata),
        .hsel_i    (hsel),
        .hready_i  (hready_bus),
        .hready_o  (hready_o),
        .hresp_o   (hresp_o),
        .hrdata_o  (hrdata_o),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .paddr_o   (paddr_o),
        .pwrite_o  (pwrite_o),
        .pwdata_o  (pwdata_o),
        .pstrb_o   (pstrb_o),
        .prdata_i  (prdata),
        .pready_i  (pready),
        .pslverr_i (pslverr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [AW-1:0] a, input logic w, input logic [2:0] sz);
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        htrans = 2'b10;
        hsel   = 1'b1;
    endtask

    task automatic bus_idle();
        htrans = 2'b00;
        hsel   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waits;
        int acc;
        logic done;

        rst = 1'b1; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
        hwdata = '0; hsel = 1'b0; pready = '1; pslverr = '0; prdata = '0;
        prdata[0  +: 32] = 32'hCAFE_F00D;
        prdata[32 +: 32] = 32'hDEAD_BEEF;
        prdata[64 +: 32] = 32'h0BAD_0BAD;
        tick(); tick();

        // Reset values
        @(negedge clk);
        check_eq("rst_psel", 32'(psel_o), 32'h0);
        check_eq("rst_penable", 32'(penable_o), 32'h0);
        check_eq("rst_hready", 32'(hready_o), 32'h1);
        check_eq("rst_hresp", 32'(hresp_o), 32'h0);
        check_eq("rst_hrdata", hrdata_o, 32'h0);
        tick();
        rst = 1'b0;

        // BUSY transfer is ignored
        hsel = 1'b1; htrans = 2'b01; haddr = 16'h2000;
        tick();
        bus_idle();
        @(negedge clk);
        check_eq("busy_psel", 32'(psel_o), 32'h0);
        check_eq("busy_hready", 32'(hready_o), 32'h1);
        tick();

        // Word write to slave 2, zero-wait
        addr_phase(16'h2004, 1'b1, 3'd2);
        @(negedge clk);
        check_eq("wr_c0_hready", 32'(hready_o), 32'h1);
        tick();
        bus_idle();
        hwdata = 32'h1234_5678;
        @(negedge clk);
        check_eq("wr_setup_psel", 32'(psel_o), 32'h4);
        check_eq("wr_setup_penable", 32'(penable_o), 32'h0);
        check_eq("wr_setup_pstrb", 32'(pstrb_o), 32'hF);
        check_eq("wr_setup_paddr", 32'(paddr_o), 32'h2004);
        check_eq("wr_setup_hready", 32'(hready_o), 32'h0);
        tick();
        @(negedge clk);
        check_eq("wr_acc_penable", 32'(penable_o), 32'h1);
        check_eq("wr_acc_pwdata", pwdata_o, 32'h1234_5678);
        check_eq("wr_acc_pwrite", 32'(pwrite_o), 32'h1);
        tick();
        @(negedge clk);
        check_eq("wr_done_hready", 32'(hready_o), 32'h1);
        check_eq("wr_done_hresp", 32'(hresp_o), 32'h0);
        check_eq("wr_done_psel", 32'(psel_o), 32'h0);
        tick();

        // Read slave 0 with three not-ready ACCESS cycles
        addr_phase(16'h0100, 1'b0, 3'd2);
        pready = 4'b1110;
        tick();
        bus_idle();
        waits = 0; acc = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (hready_o) begin
                done = 1'b1;
            end else begin
                waits++;
                if (penable_o) begin
                    if (acc == 0) check_eq("rd_pstrb", 32'(pstrb_o), 32'h0);
                    acc++;
                    if (acc == 4) pready[0] = 1'b1;
                end
                tick();
            end
        end
        check_eq("rd_done", 32'(done), 32'h1);
        check_eq("rd_waits", 32'(waits), 32'd5);
        check_eq("rd_hrdata", hrdata_o, 32'hCAFE_F00D);
        check_eq("rd_hresp", 32'(hresp_o), 32'h0);
        tick();
        pready = '1;

        // Out-of-range window (index 5)
        addr_phase(16'h5000, 1'b0, 3'd2);
        tick();
        bus_idle();
        @(negedge clk);
        check_eq("dec_err1_psel", 32'(psel_o), 32'h0);
        check_eq("dec_err1_hresp", 32'(hresp_o), 32'h1);
        check_eq("dec_err1_hready", 32'(hready_o), 32'h0);
        tick();
        @(negedge clk);
        check_eq("dec_err2_hresp", 32'(hresp_o), 32'h1);
        check_eq("dec_err2_hready", 32'(hready_o), 32'h1);
        tick();
        @(negedge clk);
        check_eq("dec_after_hresp", 32'(hresp_o), 32'h0);
        tick();

        // Slave 1 returns PSLVERR
        addr_phase(16'h1000, 1'b0, 3'd2);
        pslverr = 4'b0010;
        tick();
        bus_idle();
        @(negedge clk);
        check_eq("slverr_setup_psel", 32'(psel_o), 32'h2);
        tick();
        @(negedge clk);
        check_eq("slverr_acc_penable", 32'(penable_o), 32'h1);
        tick();
        @(negedge clk);
        check_eq("slverr_e1", {hresp_o, hready_o, psel_o}, {26'h0, 1'b1, 1'b0, 4'h0});
        tick();
        @(negedge clk);
        check_eq("slverr_e2", {hresp_o, hready_o}, 32'h3);
        tick();
        pslverr = '0;

        // Halfword write at 0x1002
        addr_phase(16'h1002, 1'b1, 3'd1);
        tick();
        bus_idle();
        hwdata = 32'hABCD_0000;
        @(negedge clk);
        check_eq("half_pstrb", 32'(pstrb_o), 32'hC);
        check_eq("half_psel", 32'(psel_o), 32'h2);
        tick();
        @(negedge clk);
        check_eq("half_pwdata", pwdata_o, 32'hABCD_0000);
        tick();
        @(negedge clk);
        check_eq("half_done", 32'(hready_o), 32'h1);
        tick();

        // Byte write at 0x3003
        addr_phase(16'h3003, 1'b1, 3'd0);
        tick();
        bus_idle();
        @(negedge clk);
        check_eq("byte_pstrb", 32'(pstrb_o), 32'h8);
        check_eq("byte_psel", 32'(psel_o), 32'h8);
        tick();
        tick();
        @(negedge clk);
        check_eq("byte_done", 32'(hready_o), 32'h1);
        tick();

        // Back-to-back writes: second address phase in the completion cycle
        addr_phase(16'h0000, 1'b1, 3'd2);
        tick();
        bus_idle();
        hwdata = 32'h1111_1111;
        @(negedge clk);
        check_eq("b2b_a_psel", 32'(psel_o), 32'h1);
        tick();
        @(negedge clk);
        check_eq("b2b_a_pwdata", pwdata_o, 32'h1111_1111);
        tick();
        addr_phase(16'h3008, 1'b1, 3'd2);
        @(negedge clk);
        check_eq("b2b_a_done", 32'(hready_o), 32'h1);
        tick();
        bus_idle();
        hwdata = 32'h2222_2222;
        @(negedge clk);
        check_eq("b2b_b_psel", 32'(psel_o), 32'h8);
        check_eq("b2b_b_paddr", 32'(paddr_o), 32'h3008);
        check_eq("b2b_b_penable", 32'(penable_o), 32'h0);
        tick();
        @(negedge clk);
        check_eq("b2b_b_pwdata", pwdata_o, 32'h2222_2222);
        tick();
        @(negedge clk);
        check_eq("b2b_b_done", 32'(hready_o), 32'h1);
        tick();

        // Misaligned word, then size 3 accepted during ERR2
        addr_phase(16'h0002, 1'b1, 3'd2);
        tick();
        bus_idle();
        @(negedge clk);
        check_eq("mis_e1", {hresp_o, hready_o, psel_o}, {26'h0, 1'b1, 1'b0, 4'h0});
        tick();
        addr_phase(16'h0000, 1'b0, 3'd3);
        @(negedge clk);
        check_eq("mis_e2", {hresp_o, hready_o}, 32'h3);
        tick();
        bus_idle();
        @(negedge clk);
        check_eq("size3_e1", {hresp_o, hready_o, psel_o}, {26'h0, 1'b1, 1'b0, 4'h0});
        tick();
        tick();
        @(negedge clk);
        check_eq("size3_after", {hresp_o, hready_o}, 32'h1);
        tick();

        // Reset asserted during ACCESS
        addr_phase(16'h2000, 1'b1, 3'd2);
        pready = 4'b1011;
        tick();
        bus_idle();
        hwdata = 32'h5A5A_5A5A;
        tick();
        @(negedge clk);
        check_eq("rstacc_psel_pre", 32'(psel_o), 32'h4);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_eq("rstacc_psel", 32'(psel_o), 32'h0);
        check_eq("rstacc_penable", 32'(penable_o), 32'h0);
        check_eq("rstacc_paddr", 32'(paddr_o), 32'h0);
        check_eq("rstacc_pwdata", pwdata_o, 32'h0);
        check_eq("rstacc_pstrb", 32'(pstrb_o), 32'h0);
        check_eq("rstacc_pwrite", 32'(pwrite_o), 32'h0);
        check_eq("rstacc_hrdata", hrdata_o, 32'h0);
        check_eq("rstacc_hready", 32'(hready_o), 32'h1);
        check_eq("rstacc_hresp", 32'(hresp_o), 32'h0);
        tick();
        rst = 1'b0;
        pready = '1;
        @(negedge clk);
        check_eq("rstacc_after_psel", 32'(psel_o), 32'h0);
        tick();

`ifdef AHB2APB_TIMEOUT_EN
        // Stuck slave aborts after TIMEOUT ACCESS cycles
        pready = '0;
        addr_phase(16'h1000, 1'b0, 3'd2);
        tick();
        bus_idle();
        acc = 0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (hresp_o) begin
                done = 1'b1;
            end else begin
                if (penable_o) acc++;
                tick();
            end
        end
        check_eq("to_abort", 32'(done), 32'h1);
        check_eq("to_acc_cycles", 32'(acc), 32'd4);
        check_eq("to_e1", {hready_o, psel_o, penable_o}, 32'h0);
        pready = '1;
        tick();
        @(negedge clk);
        check_eq("to_e2", {hresp_o, hready_o, psel_o}, {26'h0, 1'b1, 1'b1, 4'h0});
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb2apb_bridge_mslv.md
# ahb2apb_bridge_mslv

AHB-Lite slave to APB4 bridge fanning one AHB port out to `NUM_SLV` APB slaves. It decodes the slave index from the address, generates `pstrb` from `hsize`/`haddr`, and returns `pslverr` and decode errors as the AHB two-cycle ERROR response. It supports back-to-back transfers and an optional APB access timeout. It sits between the system AHB interconnect and the peripheral APB segment.

## Interface
- `ADDR_WIDTH`, 16: AHB/APB address width.
- `NUM_SLV`, 4: number of APB slaves (1..16).
- `SLV_ADDR_W`, 12: address bits per slave window; slave index is `haddr_i[SLV_ADDR_W +: clog2(NUM_SLV)]` (1 bit min).
- `TIMEOUT`, 255: maximum ACCESS cycles before abort (timeout build only).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; one clock, synchronous, active-high.
- `haddr_i` in ADDR_WIDTH: AHB address.
- `htrans_i` in 2: AHB transfer type.
- `hwrite_i` in 1: 1 = write.
- `hsize_i` in 3: transfer size.
- `hwdata_i` in 32: write data (data phase).
- `hsel_i` in 1: bridge select.
- `hready_i` in 1: bus-wide ready.
- `hready_o` out 1: data phase complete.
- `hresp_o` out 1: 1 = ERROR.
- `hrdata_o` out 32: read data.
- `psel_o` out NUM_SLV: one-hot slave select.
- `penable_o` out 1: APB enable.
- `paddr_o` out ADDR_WIDTH: APB address.
- `pwrite_o` out 1: APB direction.
- `pwdata_o` out 32: APB write data.
- `pstrb_o` out 4: byte strobes (0 on reads).
- `prdata_i` in 32*NUM_SLV: read data, slave k at `[32k +: 32]`.
- `pready_i` in NUM_SLV: per-slave ready.
- `pslverr_i` in NUM_SLV: per-slave error.

## Operation
- Accept when `hsel_i & hready_i & htrans_i[1]`. Capture addr, write, size and index. IDLE/BUSY transfers are ignored, and OKAY is returned with zero wait.
- Decode error when index >= NUM_SLV, when `hsize_i` > 2, or when the address is misaligned for its size. Go to ERR1 with no APB access.
- States and transitions:
  - IDLE -> SETUP on a valid accept.
  - SETUP -> ACCESS always.
  - ACCESS -> IDLE on the selected `pready_i` with `pslverr_i`=0.
  - ACCESS -> ERR1 on the selected `pready_i` with `pslverr_i`=1, or on timeout.
  - ERR1 -> ERR2 always.
  - ERR2 -> IDLE, or -> SETUP/ERR1 if a new transfer is accepted in ERR2.
- IDLE: `hready_o`=1, `hresp_o`=0. A new accept here chains a back-to-back transfer.
- SETUP: `psel_o[idx]`=1, `penable_o`=0. `paddr_o`/`pwrite_o`/`pstrb_o` are registered. `pwdata_o` is registered from `hwdata_i` on SETUP entry+1, i.e. sampled during SETUP and held through ACCESS.
- ACCESS: `penable_o`=1. Hold all APB outputs until the selected `pready_i`. Other slaves' `pready_i` are ignored.
- Completion: in the cycle after ACCESS ends, `hready_o`=1. On a read, `hrdata_o` carries the registered `prdata_i` of the selected slave; otherwise `hrdata_o` holds its last value.
- `pstrb_o`: size 0 gives `1<<a[1:0]`; size 1 gives `3<<a[1:0]`; size 2 gives 4'hF.
- ERR1: `hready_o`=0, `hresp_o`=1. ERR2: `hready_o`=1, `hresp_o`=1.
- Reset: state IDLE, `psel_o`=0, `penable_o`=0, `paddr_o`=0, `pwrite_o`=0, `pwdata_o`=0, `pstrb_o`=0, `hrdata_o`=0, `hresp_o`=0, `hready_o`=1. Reset asserted mid-transfer drops `psel_o` the next edge, with no completion.

## Timing
- Read/write with zero-wait slave: address phase at cycle 0, SETUP at 1, ACCESS at 2, `hready_o`=1 at 3. That is 2 AHB wait states.
- Each cycle `pready_i`=0 in ACCESS adds one wait state.
- Decode error: ERR1 at cycle 1, ERR2 at cycle 2.
- `hready_o` is 0 in every cycle from SETUP/ERR1 entry until completion.
- All outputs are registered except `hready_o`/`hresp_o`, which decode directly from state.

## Configuration
- `AHB2APB_TIMEOUT_EN` defined:
  - An 8-bit-min counter clears on ACCESS entry and increments each ACCESS cycle.
  - At count == TIMEOUT with no `pready_i`, `psel_o`/`penable_o` are deasserted and the bridge goes to ERR1.
  - A late `pready_i` is ignored.
- `AHB2APB_TIMEOUT_EN` undefined: no counter, and ACCESS waits indefinitely.

## Structure
- Package `ahb2apb_pkg` holds:
  - the state encoding (IDLE, SETUP, ACCESS, ERR1, ERR2);
  - the HTRANS constants (IDLE/BUSY/NONSEQ/SEQ);
  - the HRESP OKAY/ERROR constants;
  - the HSIZE byte/half/word constants.
- Sub-module `ahb2apb_decoder`: combinational index, decode-error and `pstrb` generation from addr/size.

## Test plan
- Write 0x1234_5678 to 0x2004, size 2, slave 2 `pready_i`=1 -> `psel_o`=4'b0100, `pstrb_o`=4'hF, `pwdata_o`=0x12345678 at ACCESS, `hready_o`=1 at cycle 3.
- Read 0x0100 from slave 0 holding `pready_i`=0 for 3 ACCESS cycles, `prdata_i`=0xCAFE_F00D -> 5 wait states, `hrdata_o`=0xCAFEF00D with `hready_o`=1.
- Address 0x5000 with NUM_SLV=4 (index 5) -> no `psel_o`, then `hresp_o`=1/`hready_o`=0 followed by `hresp_o`=1/`hready_o`=1.
- Slave 1 returns `pslverr_i`=1 with `pready_i`=1 -> two-cycle ERROR. Halfword write at 0x1002 -> `pstrb_o`=4'b1100.
- Back-to-back NONSEQ writes during the `hready_o`=1 completion cycle -> next SETUP immediately follows, with no IDLE gap.
- With `AHB2APB_TIMEOUT_EN` and TIMEOUT=4, `pready_i` stuck 0 -> abort after 4 ACCESS cycles, then ERROR. Reset asserted in ACCESS -> all outputs reach their reset values next edge.
